sweep_scheduler: RTL
====================

Name: sweep_scheduler

Overview:
Raster-scan sequencer for the two-axis solar panel tracker. It steps the H and V servo pulse-width setpoints over a grid and waits for mechanical settling at each point. At each point it requests one ADC sample of panel voltage and records the maximum with its position. After the sweep it parks both servos at the best position. It sits between the button/control logic (START from BTN_C) and the servo PWM generators and ADC front end inside sp_optimizer.

Parameters:
POS_MIN, 50000, lowest servo pulse width (CLK cycles) on both axes
POS_MAX, 250000, highest allowed pulse width on both axes
POS_STEP, 10000, grid increment on both axes
SETTLE_CYCLES, 1000000, CLK cycles to wait after every setpoint change (minimum 1)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
START  in  1  begin sweep; sampled only in IDLE
ABORT  in  1  cancel sweep; return to IDLE
adc_req  out  1  sample request to ADC; held until adc_valid
adc_valid  in  1  V_in valid this cycle
V_in  in  12  ADC panel voltage
servo_position_H  out  32  H servo pulse-width setpoint
servo_position_V  out  32  V servo pulse-width setpoint
max_V_in  out  12  largest V_in seen in current/last sweep
pulseWidth_max_H  out  32  H position of max_V_in
pulseWidth_max_V  out  32  V position of max_V_in
STAT  out  3  state code
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset (async, RST_N=0): state IDLE, servo_position_H/V=POS_MIN, pulseWidth_max_H/V=POS_MIN, max_V_in=0, adc_req=0, busy=0, done=0, settle counter=0. Outputs take these values immediately, without a clock edge.
- STAT encoding: IDLE=000, SETTLE=001, SAMPLE=010, STEP=011, PARK=100, DONE=101.
- IDLE: if START=1 on a CLK edge, then on that edge:
  - set H=V=POS_MIN and max_V_in=0;
  - set pulseWidth_max_H/V=POS_MIN;
  - load counter=SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE: decrement counter each cycle. When counter==0, go to SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: adc_req=1, combinational from state. On a cycle with adc_valid=1:
  - if V_in > max_V_in (strict), load max_V_in=V_in and pulseWidth_max_H/V=current positions;
  - go to STEP.
  - Ties keep the earliest point.
  - adc_valid outside SAMPLE is ignored.
  - There is no timeout; SAMPLE waits indefinitely.
- STEP (1 cycle):
  - if H+POS_STEP <= POS_MAX: H += POS_STEP, load counter, go to SETTLE;
  - else if V+POS_STEP <= POS_MAX: H=POS_MIN, V += POS_STEP, load counter, go to SETTLE;
  - else: H=pulseWidth_max_H, V=pulseWidth_max_V, load counter, go to PARK.
  - Sums are computed at 33 bits, so there is no wrap-around.
  - Points per axis N=floor((POS_MAX-POS_MIN)/POS_STEP)+1. A sweep issues exactly N*N adc_req handshakes.
- PARK: decrement counter as in SETTLE. When 0, go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. Positions and max registers hold until the next START.
- ABORT=1 in any non-IDLE state takes priority over all transitions:
  - next state is IDLE and adc_req drops;
  - positions and max registers freeze at current values;
  - done stays 0.
- START while busy is ignored. START held high after DONE starts a new sweep from IDLE.
- The position order is V outer, H inner: (MIN,MIN), (MIN+STEP,MIN), … Each row starts at H=POS_MIN.

Test Plan:
All scenarios use POS_MIN=100, POS_MAX=140, POS_STEP=20, SETTLE_CYCLES=4 (3x3 grid, 9 samples).
1. Reset:
   - Stimulus: assert RST_N=0 between clock edges.
   - Required: positions=100, max_V_in=0, STAT=000, adc_req=0, busy=0 immediately.
2. Full sweep with peak:
   - Stimulus: ADC model returns adc_valid 1 cycle after adc_req; V_in=3000 at (H=120,V=140), 500 elsewhere.
   - Required: 9 handshakes in raster order; max_V_in=3000; pulseWidth_max_H=120, pulseWidth_max_V=140; final positions (120,140); single done pulse; STAT returns to 000.
3. Tie rule:
   - Stimulus: all samples return 1000.
   - Required: max_V_in=1000; pulseWidth_max_H/V=(100,100); park at (100,100).
4. ADC latency:
   - Stimulus: adc_valid delayed 7 cycles, plus a spurious adc_valid pulse during SETTLE.
   - Required: adc_req held high the full 7 cycles; spurious pulse ignored; positions do not change until capture; result identical to scenario 2.
5. Abort and restart:
   - Stimulus: ABORT during the 4th SETTLE.
   - Required: IDLE next cycle, positions stay (100,120), no done. A new START then resets max_V_in to 0, positions to (100,100), and completes a 9-sample sweep.
6. Async reset mid-SAMPLE:
   - Stimulus: RST_N=0 with adc_req=1.
   - Required: adc_req=0 and all outputs at reset values with no CLK edge; after release, IDLE until START.

Source files
------------

// File: rtl/sweep_scheduler.sv
// Raster-scan sequencer for the two-axis solar tracker: steps H/V servo
// setpoints over a grid, settles, samples panel voltage, parks at the best point.
module sweep_scheduler #(
    parameter int unsigned POS_MIN       = 50000,
    parameter int unsigned POS_MAX       = 250000,
    parameter int unsigned POS_STEP      = 10000,
    parameter int unsigned SETTLE_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        ABORT,
    output logic        adc_req,
    input  logic        adc_valid,
    input  logic [11:0] V_in,
    output logic [31:0] servo_position_H,
    output logic [31:0] servo_position_V,
    output logic [11:0] max_V_in,
    output logic [31:0] pulseWidth_max_H,
    output logic [31:0] pulseWidth_max_V,
    output logic [2:0]  STAT,
    output logic        busy,
    output logic        done
);

    localparam int unsigned POS_W = 32;
    localparam int unsigned ADC_W = 12;
    localparam int unsigned CNT_W = 32;

    localparam logic [POS_W-1:0] MIN_P       = POS_W'(POS_MIN);
    localparam logic [POS_W:0]   MAX_X       = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   STEP_X      = (POS_W+1)'(POS_STEP);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_SETTLE = 3'b001,
        S_SAMPLE = 3'b010,
        S_STEP   = 3'b011,
        S_PARK   = 3'b100,
        S_DONE   = 3'b101
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   h_q, h_d;
    logic [POS_W-1:0]   v_q, v_d;
    logic [POS_W-1:0]   best_h_q, best_h_d;
    logic [POS_W-1:0]   best_v_q, best_v_d;
    logic [ADC_W-1:0]   max_v_q, max_v_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W:0]     h_next_x;
    logic [POS_W:0]     v_next_x;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            h_q      <= MIN_P;
            v_q      <= MIN_P;
            best_h_q <= MIN_P;
            best_v_q <= MIN_P;
            max_v_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            best_h_q <= best_h_d;
            best_v_q <= best_v_d;
            max_v_q  <= max_v_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update; ABORT overrides everything and freezes data
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        best_h_d = best_h_q;
        best_v_d = best_v_q;
        max_v_d  = max_v_q;
        cnt_d    = cnt_q;
        // One extra bit so a step past the top of the range cannot wrap
        h_next_x = {1'b0, h_q} + STEP_X;
        v_next_x = {1'b0, v_q} + STEP_X;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    h_d      = MIN_P;
                    v_d      = MIN_P;
                    best_h_d = MIN_P;
                    best_v_d = MIN_P;
                    max_v_d  = '0;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
                if (adc_valid) begin
                    // Strict compare: ties keep the earliest grid point
                    if (V_in > max_v_q) begin
                        max_v_d  = V_in;
                        best_h_d = h_q;
                        best_v_d = v_q;
                    end
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                cnt_d = SETTLE_LOAD;
                if (h_next_x <= MAX_X) begin
                    h_d     = h_next_x[POS_W-1:0];
                    state_d = S_SETTLE;
                end else if (v_next_x <= MAX_X) begin
                    h_d     = MIN_P;
                    v_d     = v_next_x[POS_W-1:0];
                    state_d = S_SETTLE;
                end else begin
                    h_d     = best_h_q;
                    v_d     = best_v_q;
                    state_d = S_PARK;
                end
            end
            S_PARK: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ABORT && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            h_d      = h_q;
            v_d      = v_q;
            best_h_d = best_h_q;
            best_v_d = best_v_q;
            max_v_d  = max_v_q;
            cnt_d    = cnt_q;
        end
    end

    // Status and handshake decode straight from the state register
    assign adc_req          = (state_q == S_SAMPLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign STAT             = state_q;
    assign servo_position_H = h_q;
    assign servo_position_V = v_q;
    assign max_V_in         = max_v_q;
    assign pulseWidth_max_H = best_h_q;
    assign pulseWidth_max_V = best_v_q;

endmodule
